vfu_mbus_wb_bridge: RTL and testbench

//  Downstream of the Vfu memory port: converts the Vfu mbus AR/R/AW/W/B channels into one

---
 rtl/vfu_mbus_wb_bridge_if.sv | 47 ++++
 rtl/vfu_mbus_wb_bridge.sv | 154 +++++++++++++++
 tb/tb_vfu_mbus_wb_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vfu_mbus_wb_bridge_if.sv
// Bundles the Vfu mbus AR/R/AW/W/B channels and the Wishbone-classic master signals.
// The slave modport is the bridge's view; the master modport is the Vfu plus SoC-bus view.
interface vfu_mbus_wb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   mbus_ar_addr;
    logic                    mbus_ar_valid;
    logic                    mbus_ar_ready;
    logic [DATA_WIDTH-1:0]   mbus_r_data;
    logic                    mbus_r_valid;
    logic                    mbus_r_ready;
    logic [ADDR_WIDTH-1:0]   mbus_aw_addr;
    logic                    mbus_aw_valid;
    logic                    mbus_aw_ready;
    logic [DATA_WIDTH-1:0]   mbus_w_data;
    logic [DATA_WIDTH/8-1:0] mbus_w_strb;
    logic                    mbus_w_valid;
    logic                    mbus_b_resp;
    logic                    mbus_b_valid;
    logic                    mbus_b_ready;
    logic [ADDR_WIDTH-3:0]   wb_adr;
    logic [DATA_WIDTH-1:0]   wb_dat_w;
    logic [DATA_WIDTH-1:0]   wb_dat_r;
    logic [DATA_WIDTH/8-1:0] wb_sel;
    logic                    wb_cyc;
    logic                    wb_stb;
    logic                    wb_we;
    logic                    wb_ack;
    logic                    wb_err;

    modport slave (
        input  mbus_ar_addr, mbus_ar_valid, mbus_r_ready,
        input  mbus_aw_addr, mbus_aw_valid, mbus_w_data, mbus_w_strb, mbus_w_valid, mbus_b_ready,
        input  wb_dat_r, wb_ack, wb_err,
        output mbus_ar_ready, mbus_r_data, mbus_r_valid, mbus_aw_ready, mbus_b_resp, mbus_b_valid,
        output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we
    );

    modport master (
        output mbus_ar_addr, mbus_ar_valid, mbus_r_ready,
        output mbus_aw_addr, mbus_aw_valid, mbus_w_data, mbus_w_strb, mbus_w_valid, mbus_b_ready,
        output wb_dat_r, wb_ack, wb_err,
        input  mbus_ar_ready, mbus_r_data, mbus_r_valid, mbus_aw_ready, mbus_b_resp, mbus_b_valid,
        input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we
    );
endinterface

// File: rtl/vfu_mbus_wb_bridge.sv
// Vfu mbus to Wishbone-classic bridge: single-beat, one-outstanding transactions with a
// W-beat FIFO, alternating read/write priority and a bus timeout.
module vfu_mbus_wb_bridge #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int WFIFO_DEPTH_BITS = 4,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vfu_mbus_wb_bridge_if.slave      bus,
    output logic                     err_sticky
);
    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int DEPTH       = 2 ** WFIFO_DEPTH_BITS;
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RD, WR, RD_RSP, WR_RSP} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0]       fifo_data [DEPTH];
    logic [STRB_WIDTH-1:0]       fifo_strb [DEPTH];
    logic [WFIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [WFIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [WFIFO_DEPTH_BITS:0]   count;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        push;
    logic                        overflow;
    logic                        prio_rd;
    logic [TIMER_WIDTH-1:0]      timer;
    logic                        cyc;
    logic                        rd_req;
    logic                        wr_req;
    logic                        grant_rd;
    logic                        grant_wr;
    logic                        timed_out;
    logic                        terminate;
    logic                        ok;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (WFIFO_DEPTH_BITS + 1)'(DEPTH));
    assign push       = bus.mbus_w_valid & ~fifo_full;
    assign overflow   = bus.mbus_w_valid & fifo_full;

    // A write is only requestable once its data beat is already buffered.
    assign rd_req   = bus.mbus_ar_valid;
    assign wr_req   = bus.mbus_aw_valid & ~fifo_empty;
    assign grant_rd = rst_n && (state == IDLE) && rd_req && (!wr_req || prio_rd);
    assign grant_wr = rst_n && (state == IDLE) && wr_req && (!rd_req || !prio_rd);

    assign bus.mbus_ar_ready = grant_rd;
    assign bus.mbus_aw_ready = grant_wr;

    assign timed_out = (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
    assign terminate = bus.wb_ack | bus.wb_err | timed_out;
    assign ok        = bus.wb_ack & ~bus.wb_err;

    assign bus.wb_cyc = cyc;
    assign bus.wb_stb = cyc;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.mbus_w_data;
            fifo_strb[wr_ptr] <= bus.mbus_w_strb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cyc             <= 1'b0;
            bus.wb_we       <= 1'b0;
            bus.wb_adr      <= '0;
            bus.wb_dat_w    <= '0;
            bus.wb_sel      <= '0;
            bus.mbus_r_data <= '0;
            bus.mbus_r_valid <= 1'b0;
            bus.mbus_b_valid <= 1'b0;
            bus.mbus_b_resp <= 1'b0;
            err_sticky      <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            prio_rd         <= 1'b1;
            timer           <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (grant_wr) rd_ptr <= rd_ptr + 1'b1;
            if (push && !grant_wr) count <= count + 1'b1;
            else if (grant_wr && !push) count <= count - 1'b1;
            if (overflow) err_sticky <= 1'b1;

            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        bus.wb_adr <= bus.mbus_ar_addr[ADDR_WIDTH-1:2];
                        bus.wb_sel <= '1;
                        bus.wb_we  <= 1'b0;
                        cyc        <= 1'b1;
                        timer      <= '0;
                        prio_rd    <= 1'b0;
                        state      <= RD;
                    end else if (grant_wr) begin
                        bus.wb_adr   <= bus.mbus_aw_addr[ADDR_WIDTH-1:2];
                        bus.wb_dat_w <= fifo_data[rd_ptr];
                        bus.wb_sel   <= fifo_strb[rd_ptr];
                        bus.wb_we    <= 1'b1;
                        cyc          <= 1'b1;
                        timer        <= '0;
                        prio_rd      <= 1'b1;
                        state        <= WR;
                    end
                end
                RD: begin
                    if (terminate) begin
                        cyc              <= 1'b0;
                        bus.mbus_r_data  <= ok ? bus.wb_dat_r : '0;
                        bus.mbus_r_valid <= 1'b1;
                        if (!ok) err_sticky <= 1'b1;
                        state            <= RD_RSP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WR: begin
                    if (terminate) begin
                        cyc              <= 1'b0;
                        bus.wb_we        <= 1'b0;
                        bus.mbus_b_resp  <= ~ok;
                        bus.mbus_b_valid <= 1'b1;
                        if (!ok) err_sticky <= 1'b1;
                        state            <= WR_RSP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RD_RSP: begin
                    if (bus.mbus_r_ready) begin
                        bus.mbus_r_valid <= 1'b0;
                        state            <= IDLE;
                    end
                end
                WR_RSP: begin
                    if (bus.mbus_b_ready) begin
                        bus.mbus_b_valid <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vfu_mbus_wb_bridge.sv
// Directed self-checking bench for vfu_mbus_wb_bridge with a combinational zero-wait
// Wishbone slave whose ack/err can be disabled per test.
module tb_vfu_mbus_wb_bridge;
    logic clk;
    logic rst_n;
    logic err_sticky;
    logic ack_en;
    logic err_en;
    logic [31:0] slave_rdata;
    int checks;
    int errors;

    logic [31:0] wr_dat_q [$];
    logic [3:0]  wr_sel_q [$];

    vfu_mbus_wb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    vfu_mbus_wb_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .WFIFO_DEPTH_BITS(4), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .err_sticky(err_sticky)
    );

    assign bus.wb_ack   = bus.wb_cyc & bus.wb_stb & ack_en;
    assign bus.wb_err   = bus.wb_cyc & bus.wb_stb & err_en;
    assign bus.wb_dat_r = slave_rdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log every successfully terminated Wishbone write so drain order can be checked.
    always @(posedge clk) begin
        if (bus.wb_cyc && bus.wb_stb && bus.wb_we && bus.wb_ack && !bus.wb_err) begin
            wr_dat_q.push_back(bus.wb_dat_w);
            wr_sel_q.push_back(bus.wb_sel);
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushW(input logic [31:0] data, input logic [3:0] strb);
        bus.mbus_w_data  = data;
        bus.mbus_w_strb  = strb;
        bus.mbus_w_valid = 1'b1;
        tick();
        bus.mbus_w_valid = 1'b0;
    endtask

    task automatic doRead(input logic [31:0] addr, output logic [31:0] data, output int cyc_cycles);
        int n;
        bus.mbus_ar_addr  = addr;
        bus.mbus_ar_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.mbus_ar_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("rd_grant", 64'(bus.mbus_ar_ready), 64'd1);
        tick();
        bus.mbus_ar_valid = 1'b0;
        cyc_cycles = 0;
        n = 0;
        while (!bus.mbus_r_valid && n < 400) begin
            if (bus.wb_cyc) cyc_cycles++;
            tick();
            n++;
        end
        checkOutput("rd_rvalid", 64'(bus.mbus_r_valid), 64'd1);
        data = bus.mbus_r_data;
        bus.mbus_r_ready = 1'b1;
        tick();
        bus.mbus_r_ready = 1'b0;
    endtask

    task automatic doWrite(input logic [31:0] addr, output logic resp);
        int n;
        bus.mbus_aw_addr  = addr;
        bus.mbus_aw_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.mbus_aw_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("wr_grant", 64'(bus.mbus_aw_ready), 64'd1);
        tick();
        bus.mbus_aw_valid = 1'b0;
        n = 0;
        while (!bus.mbus_b_valid && n < 400) begin
            tick();
            n++;
        end
        checkOutput("wr_bvalid", 64'(bus.mbus_b_valid), 64'd1);
        resp = bus.mbus_b_resp;
        bus.mbus_b_ready = 1'b1;
        tick();
        bus.mbus_b_ready = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic applyStimulus();
        logic [31:0] rdata;
        logic        resp;
        int          cyc_n;
        int          grants;
        int          base;

        // Reset state
        doReset();
        checkOutput("rst_cyc", 64'(bus.wb_cyc), 64'd0);
        checkOutput("rst_rvalid", 64'(bus.mbus_r_valid), 64'd0);
        checkOutput("rst_bvalid", 64'(bus.mbus_b_valid), 64'd0);
        checkOutput("rst_rdata", 64'(bus.mbus_r_data), 64'd0);
        checkOutput("rst_err", 64'(err_sticky), 64'd0);

        // Zero-wait read with cycle-exact latency
        ack_en = 1'b1;
        slave_rdata = 32'hCAFE_F00D;
        bus.mbus_ar_addr  = 32'h1000_0010;
        bus.mbus_ar_valid = 1'b1;
        #1;
        checkOutput("t1_ar_ready", 64'(bus.mbus_ar_ready), 64'd1);
        checkOutput("t1_aw_ready", 64'(bus.mbus_aw_ready), 64'd0);
        tick();
        bus.mbus_ar_valid = 1'b0;
        checkOutput("t1_cyc", 64'(bus.wb_cyc), 64'd1);
        checkOutput("t1_stb", 64'(bus.wb_stb), 64'd1);
        checkOutput("t1_adr", 64'(bus.wb_adr), 64'h0400_0004);
        checkOutput("t1_we", 64'(bus.wb_we), 64'd0);
        checkOutput("t1_sel", 64'(bus.wb_sel), 64'hF);
        checkOutput("t1_rvalid_early", 64'(bus.mbus_r_valid), 64'd0);
        tick();
        slave_rdata = 32'h0;
        checkOutput("t1_cyc_drop", 64'(bus.wb_cyc), 64'd0);
        checkOutput("t1_rvalid", 64'(bus.mbus_r_valid), 64'd1);
        checkOutput("t1_rdata", 64'(bus.mbus_r_data), 64'hCAFE_F00D);
        tick();
        checkOutput("t1_rvalid_hold", 64'(bus.mbus_r_valid), 64'd1);
        checkOutput("t1_rdata_hold", 64'(bus.mbus_r_data), 64'hCAFE_F00D);
        bus.mbus_r_ready = 1'b1;
        tick();
        bus.mbus_r_ready = 1'b0;
        checkOutput("t1_rvalid_done", 64'(bus.mbus_r_valid), 64'd0);

        // Write with W beat queued before AW
        pushW(32'h1122_3344, 4'b0110);
        bus.mbus_aw_addr  = 32'h20;
        bus.mbus_aw_valid = 1'b1;
        #1;
        checkOutput("t2_aw_ready", 64'(bus.mbus_aw_ready), 64'd1);
        tick();
        bus.mbus_aw_valid = 1'b0;
        checkOutput("t2_cyc", 64'(bus.wb_cyc), 64'd1);
        checkOutput("t2_we", 64'(bus.wb_we), 64'd1);
        checkOutput("t2_sel", 64'(bus.wb_sel), 64'b0110);
        checkOutput("t2_adr", 64'(bus.wb_adr), 64'h8);
        checkOutput("t2_dat", 64'(bus.wb_dat_w), 64'h1122_3344);
        tick();
        checkOutput("t2_we_drop", 64'(bus.wb_we), 64'd0);
        checkOutput("t2_bvalid", 64'(bus.mbus_b_valid), 64'd1);
        checkOutput("t2_bresp", 64'(bus.mbus_b_resp), 64'd0);
        bus.mbus_b_ready = 1'b1;
        tick();
        bus.mbus_b_ready = 1'b0;
        checkOutput("t2_bvalid_done", 64'(bus.mbus_b_valid), 64'd0);

        // Simultaneous requests alternate; the last grant was a write so a read goes first
        pushW(32'hBEEF_0001, 4'hF);
        pushW(32'hBEEF_0002, 4'hF);
        bus.mbus_ar_addr  = 32'h100;
        bus.mbus_aw_addr  = 32'h200;
        bus.mbus_ar_valid = 1'b1;
        bus.mbus_aw_valid = 1'b1;
        bus.mbus_r_ready  = 1'b1;
        bus.mbus_b_ready  = 1'b1;
        #1;
        grants = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            if (bus.mbus_ar_ready || bus.mbus_aw_ready) begin
                checkOutput($sformatf("t3_grant%0d", grants),
                            64'({bus.mbus_ar_ready, bus.mbus_aw_ready}),
                            (grants % 2 == 0) ? 64'b10 : 64'b01);
                grants++;
            end
            tick();
        end
        bus.mbus_ar_valid = 1'b0;
        bus.mbus_aw_valid = 1'b0;
        checkOutput("t3_grant_count", 64'(grants), 64'd4);
        repeat (4) tick();
        bus.mbus_r_ready = 1'b0;
        bus.mbus_b_ready = 1'b0;

        // FIFO overflow and in-order drain
        checkOutput("t4_err_before", 64'(err_sticky), 64'd0);
        base = wr_dat_q.size();
        for (int i = 0; i < 17; i++) begin
            bus.mbus_w_data  = 32'hA000_0000 + 32'(i);
            bus.mbus_w_strb  = 4'(i);
            bus.mbus_w_valid = 1'b1;
            tick();
        end
        bus.mbus_w_valid = 1'b0;
        checkOutput("t4_err_overflow", 64'(err_sticky), 64'd1);
        for (int i = 0; i < 16; i++) begin
            doWrite(32'(i * 4), resp);
            checkOutput($sformatf("t4_bresp%0d", i), 64'(resp), 64'd0);
        end
        checkOutput("t4_drain_count", 64'(wr_dat_q.size() - base), 64'd16);
        for (int i = 0; i < 16 && base + i < wr_dat_q.size(); i++) begin
            checkOutput($sformatf("t4_dat%0d", i), 64'(wr_dat_q[base + i]), 64'hA000_0000 + 64'(i));
            checkOutput($sformatf("t4_sel%0d", i), 64'(wr_sel_q[base + i]), 64'(i));
        end
        bus.mbus_aw_valid = 1'b1;
        #1;
        checkOutput("t4_empty_noaw", 64'(bus.mbus_aw_ready), 64'd0);
        tick();
        checkOutput("t4_empty_noaw2", 64'(bus.mbus_aw_ready), 64'd0);
        bus.mbus_aw_valid = 1'b0;

        // Timeout on a read, then wb_err on a write
        doReset();
        checkOutput("t5_err_cleared", 64'(err_sticky), 64'd0);
        ack_en = 1'b0;
        slave_rdata = 32'hDEAD_BEEF;
        doRead(32'h40, rdata, cyc_n);
        checkOutput("t5_timeout_cycles", 64'(cyc_n), 64'd255);
        checkOutput("t5_timeout_rdata", 64'(rdata), 64'd0);
        checkOutput("t5_timeout_err", 64'(err_sticky), 64'd1);
        err_en = 1'b1;
        pushW(32'h5555_AAAA, 4'hF);
        doWrite(32'h44, resp);
        checkOutput("t5_wberr_bresp", 64'(resp), 64'd1);
        err_en = 1'b0;

        // Asynchronous reset in the middle of a bus cycle
        pushW(32'h7777_0000, 4'hF);
        bus.mbus_ar_addr  = 32'h60;
        bus.mbus_ar_valid = 1'b1;
        tick();
        bus.mbus_ar_valid = 1'b0;
        tick();
        checkOutput("t6_cyc_before", 64'(bus.wb_cyc), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_cyc_async", 64'(bus.wb_cyc), 64'd0);
        checkOutput("t6_stb_async", 64'(bus.wb_stb), 64'd0);
        checkOutput("t6_adr_async", 64'(bus.wb_adr), 64'd0);
        checkOutput("t6_err_async", 64'(err_sticky), 64'd0);
        checkOutput("t6_rvalid_async", 64'(bus.mbus_r_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.mbus_aw_addr  = 32'h64;
        bus.mbus_aw_valid = 1'b1;
        #1;
        checkOutput("t6_fifo_discarded", 64'(bus.mbus_aw_ready), 64'd0);
        tick();
        bus.mbus_aw_valid = 1'b0;
        ack_en = 1'b1;
        slave_rdata = 32'h5A5A_1234;
        doRead(32'h80, rdata, cyc_n);
        checkOutput("t6_clean_rdata", 64'(rdata), 64'h5A5A_1234);
        checkOutput("t6_clean_cycles", 64'(cyc_n), 64'd1);
        checkOutput("t6_clean_err", 64'(err_sticky), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        ack_en = 1'b0;
        err_en = 1'b0;
        slave_rdata = 32'h0;
        bus.mbus_ar_addr  = '0;
        bus.mbus_ar_valid = 1'b0;
        bus.mbus_r_ready  = 1'b0;
        bus.mbus_aw_addr  = '0;
        bus.mbus_aw_valid = 1'b0;
        bus.mbus_w_data   = '0;
        bus.mbus_w_strb   = '0;
        bus.mbus_w_valid  = 1'b0;
        bus.mbus_b_ready  = 1'b0;
        #3;
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
